mem_dump: RTL

MEM_DUMP -- requirements
Module: mem_dump

---
 rtl/mem_dump_if.sv | 10 +
 rtl/mem_dump.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mem_dump_if.sv
// Single-port BSRAM read bus between the dump engine (master) and the memory (slave).
interface mem_dump_if;
    logic        mem_ce;
    logic        mem_wre;
    logic [10:0] mem_ad;
    logic [15:0] mem_dout;

    modport master (output mem_ce, output mem_wre, output mem_ad, input  mem_dout);
    modport slave  (input  mem_ce, input  mem_wre, input  mem_ad, output mem_dout);
endinterface

// File: rtl/mem_dump.sv
// Reads BSRAM words start_addr..end_addr (wrapping at 0x7FF) and sends each as two 8N1 UART bytes.
// Define MEM_DUMP_CHECKSUM_EN to append one mod-256 sum byte of all data bytes after the last word.
module mem_dump #(
    parameter int CLK_HZ = 27000000,
    parameter int BAUD   = 115200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [10:0]      start_addr,
    input  logic [10:0]      end_addr,
    mem_dump_if.master       mem,
    output logic             tx,
    output logic             busy,
    output logic             done
);
    localparam int              CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int              BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]      BIT_LAST     = 4'd9;
    localparam logic [9:0]      LINE_IDLE    = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_CAPTURE, S_SEND_HI, S_SEND_LO, S_NEXT, S_FINISH
`ifdef MEM_DUMP_CHECKSUM_EN
        , S_CSUM
`endif
    } state_e;

    state_e              state_q, state_d;
    logic [10:0]         cur_addr_q, cur_addr_d;
    logic [10:0]         end_addr_q, end_addr_d;
    logic [7:0]          lo_byte_q, lo_byte_d;
    logic [9:0]          shift_q, shift_d;
    logic [BAUD_W-1:0]   baud_cnt_q, baud_cnt_d;
    logic [3:0]          bit_cnt_q, bit_cnt_d;
    logic                sending, bit_end, frame_end;
`ifdef MEM_DUMP_CHECKSUM_EN
    logic [7:0]          csum_q, csum_d;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the previous cycle's values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cur_addr_q <= '0;
            end_addr_q <= '0;
            lo_byte_q  <= '0;
            shift_q    <= LINE_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            end_addr_q <= end_addr_d;
            lo_byte_q  <= lo_byte_d;
            shift_q    <= shift_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
`ifdef MEM_DUMP_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

`ifdef MEM_DUMP_CHECKSUM_EN
    assign sending = (state_q == S_SEND_HI) || (state_q == S_SEND_LO) || (state_q == S_CSUM);
`else
    assign sending = (state_q == S_SEND_HI) || (state_q == S_SEND_LO);
`endif
    assign bit_end   = (baud_cnt_q == BAUD_LAST);
    assign frame_end = bit_end && (bit_cnt_q == BIT_LAST);

    // NOTE: every next-state signal gets its hold value first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        end_addr_d = end_addr_q;
        lo_byte_d  = lo_byte_q;
        shift_d    = shift_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
`ifdef MEM_DUMP_CHECKSUM_EN
        csum_d     = csum_q;
`endif

        // Shift register holds {stop, data, start}; ones shift in so the line idles high.
        if (sending) begin
            if (bit_end) begin
                baud_cnt_d = '0;
                bit_cnt_d  = frame_end ? 4'd0 : bit_cnt_q + 4'd1;
                shift_d    = {1'b1, shift_q[9:1]};
            end else begin
                baud_cnt_d = baud_cnt_q + 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cur_addr_d = start_addr;
                    end_addr_d = end_addr;
`ifdef MEM_DUMP_CHECKSUM_EN
                    csum_d     = '0;
`endif
                    state_d    = S_ADDR;
                end
            end
            S_ADDR:    state_d = S_CAPTURE;
            S_CAPTURE: begin
                lo_byte_d  = mem.mem_dout[7:0];
                shift_d    = {1'b1, mem.mem_dout[15:8], 1'b0};
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
`ifdef MEM_DUMP_CHECKSUM_EN
                csum_d     = csum_q + mem.mem_dout[15:8] + mem.mem_dout[7:0];
`endif
                state_d    = S_SEND_HI;
            end
            S_SEND_HI: begin
                if (frame_end) begin
                    shift_d = {1'b1, lo_byte_q, 1'b0};
                    state_d = S_SEND_LO;
                end
            end
            S_SEND_LO: begin
                if (frame_end) state_d = S_NEXT;
            end
            S_NEXT: begin
                if (cur_addr_q == end_addr_q) begin
`ifdef MEM_DUMP_CHECKSUM_EN
                    shift_d    = {1'b1, csum_q, 1'b0};
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = S_CSUM;
`else
                    state_d    = S_FINISH;
`endif
                end else begin
                    cur_addr_d = cur_addr_q + 11'd1;
                    state_d    = S_ADDR;
                end
            end
`ifdef MEM_DUMP_CHECKSUM_EN
            S_CSUM: begin
                if (frame_end) state_d = S_FINISH;
            end
`endif
            S_FINISH:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    assign mem.mem_ce  = (state_q == S_ADDR);
    assign mem.mem_wre = 1'b0;
    assign mem.mem_ad  = cur_addr_q;
    assign tx          = shift_q[0];
    assign busy        = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign done        = (state_q == S_FINISH);
endmodule
